// File: rtl/sdram_rv_arbiter.sv
// sdram_rv_arbiter: shares the toggle-handshake RISC-V port of the SDRAM
// controller between instruction fetch (client 0), data (client 1) and the
// loader/OSD DMA (client 2). One transaction is outstanding at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when it is undefined the arbiter uses fixed priority 0 > 1 > 2.
module sdram_rv_arbiter #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_busy,
   output logic [ADDR_W:1]   mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic [1:0]        mem_ds,
   output logic              mem_we,
   output logic              mem_req,
   input  logic              mem_req_ack,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic [ADDR_W:1]   c0_addr,
   input  logic [DATA_W-1:0] c0_din,
   input  logic [1:0]        c0_ds,
   input  logic              c0_we,
   input  logic              c0_req,
   output logic              c0_ack,
   output logic [DATA_W-1:0] c0_dout,
   input  logic [ADDR_W:1]   c1_addr,
   input  logic [DATA_W-1:0] c1_din,
   input  logic [1:0]        c1_ds,
   input  logic              c1_we,
   input  logic              c1_req,
   output logic              c1_ack,
   output logic [DATA_W-1:0] c1_dout,
   input  logic [ADDR_W:1]   c2_addr,
   input  logic [DATA_W-1:0] c2_din,
   input  logic [1:0]        c2_ds,
   input  logic              c2_we,
   input  logic              c2_req,
   output logic              c2_ack,
   output logic [DATA_W-1:0] c2_dout
);

   localparam int unsigned NCLI = 3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e            state_q;
   logic [ADDR_W:1]   mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   logic [1:0]        mem_ds_q;
   logic              mem_we_q;
   logic              mem_req_q;
   logic [NCLI-1:0]   ack_q;
   logic [DATA_W-1:0] dout0_q;
   logic [DATA_W-1:0] dout1_q;
   logic [DATA_W-1:0] dout2_q;
   logic [1:0]        grant_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0]        rr_q;
`endif

   logic [NCLI-1:0]   pend_c;
   logic              win_vld_c;
   logic [1:0]        win_c;
   logic [ADDR_W:1]   sel_addr_c;
   logic [DATA_W-1:0] sel_din_c;
   logic [1:0]        sel_ds_c;
   logic              sel_we_c;

   // Pending clients and arbitration winner
   always_comb begin
      pend_c    = {c2_req, c1_req, c0_req} ^ ack_q;
      win_vld_c = |pend_c;
      win_c     = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
      case (rr_q)
         2'd1: begin
            if      (pend_c[1]) win_c = 2'd1;
            else if (pend_c[2]) win_c = 2'd2;
            else                win_c = 2'd0;
         end
         2'd2: begin
            if      (pend_c[2]) win_c = 2'd2;
            else if (pend_c[0]) win_c = 2'd0;
            else                win_c = 2'd1;
         end
         default: begin
            if      (pend_c[0]) win_c = 2'd0;
            else if (pend_c[1]) win_c = 2'd1;
            else                win_c = 2'd2;
         end
      endcase
`else
      if      (pend_c[0]) win_c = 2'd0;
      else if (pend_c[1]) win_c = 2'd1;
      else                win_c = 2'd2;
`endif
   end

   // Request fields of the winning client
   always_comb begin
      sel_addr_c = c0_addr;
      sel_din_c  = c0_din;
      sel_ds_c   = c0_ds;
      sel_we_c   = c0_we;
      case (win_c)
         2'd1: begin
            sel_addr_c = c1_addr;
            sel_din_c  = c1_din;
            sel_ds_c   = c1_ds;
            sel_we_c   = c1_we;
         end
         2'd2: begin
            sel_addr_c = c2_addr;
            sel_din_c  = c2_din;
            sel_ds_c   = c2_ds;
            sel_we_c   = c2_we;
         end
         default: ;
      endcase
   end

   // Issue / wait / complete FSM with registered controller and client outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_ds_q   <= '0;
         mem_we_q   <= 1'b0;
         mem_req_q  <= 1'b0;
         ack_q      <= '0;
         dout0_q    <= '0;
         dout1_q    <= '0;
         dout2_q    <= '0;
         grant_q    <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q       <= 2'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               // Controller must be in phase so mem_req is never toggled twice
               if (!mem_busy && (mem_req_q == mem_req_ack) && win_vld_c) begin
                  mem_addr_q <= sel_addr_c;
                  mem_din_q  <= sel_din_c;
                  mem_ds_q   <= sel_ds_c;
                  mem_we_q   <= sel_we_c;
                  mem_req_q  <= ~mem_req_q;
                  grant_q    <= win_c;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_req_ack == mem_req_q) state_q <= S_DONE;
            end
            S_DONE: begin
               // mem_dout is valid in this cycle only
               case (grant_q)
                  2'd1: begin
                     ack_q[1] <= ~ack_q[1];
                     if (!mem_we_q) dout1_q <= mem_dout;
                  end
                  2'd2: begin
                     ack_q[2] <= ~ack_q[2];
                     if (!mem_we_q) dout2_q <= mem_dout;
                  end
                  default: begin
                     ack_q[0] <= ~ack_q[0];
                     if (!mem_we_q) dout0_q <= mem_dout;
                  end
               endcase
`ifdef ARB_ROUND_ROBIN_EN
               rr_q    <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_ds   = mem_ds_q;
   assign mem_we   = mem_we_q;
   assign mem_req  = mem_req_q;
   assign c0_ack   = ack_q[0];
   assign c1_ack   = ack_q[1];
   assign c2_ack   = ack_q[2];
   assign c0_dout  = dout0_q;
   assign c1_dout  = dout1_q;
   assign c2_dout  = dout2_q;

endmodule

// File: tb/tb_sdram_rv_arbiter.sv
// tb_sdram_rv_arbiter: directed bench for sdram_rv_arbiter with a small
// toggle-handshake controller model that returns (addr[16:1] ^ 16'hA5A5)
// on the cycle after its ack toggles and 16'h0BAD on every other cycle.
module tb_sdram_rv_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_busy;
   logic [20:1] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_ds;
   logic        mem_we;
   logic        mem_req;
   logic        mem_req_ack;
   logic [15:0] mem_dout;

   logic [20:1] c_addr [3];
   logic [15:0] c_din  [3];
   logic [1:0]  c_ds   [3];
   logic [15:0] c_dout [3];
   logic [2:0]  c_we;
   logic [2:0]  c_req;
   logic [2:0]  c_ack;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mdl_tog_cyc = 0;
   int mcnt   = 0;
   logic        dv = 1'b0;
   logic [15:0] rd_val = 16'h0;
   int log_id [$];
   int log_t  [$];

   sdram_rv_arbiter dut (
      .clk(clk), .resetn(resetn), .mem_busy(mem_busy),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds), .mem_we(mem_we),
      .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_dout(mem_dout),
      .c0_addr(c_addr[0]), .c0_din(c_din[0]), .c0_ds(c_ds[0]), .c0_we(c_we[0]),
      .c0_req(c_req[0]), .c0_ack(c_ack[0]), .c0_dout(c_dout[0]),
      .c1_addr(c_addr[1]), .c1_din(c_din[1]), .c1_ds(c_ds[1]), .c1_we(c_we[1]),
      .c1_req(c_req[1]), .c1_ack(c_ack[1]), .c1_dout(c_dout[1]),
      .c2_addr(c_addr[2]), .c2_din(c_din[2]), .c2_ds(c_ds[2]), .c2_we(c_we[2]),
      .c2_req(c_req[2]), .c2_ack(c_ack[2]), .c2_dout(c_dout[2])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Controller model: acks three negedges after a request toggle, data one cycle later
   always @(negedge clk) begin
      mem_dout = 16'h0BAD;
      if (!resetn) begin
         mem_req_ack = 1'b0;
         mcnt        = 0;
         dv          = 1'b0;
      end else begin
         if (dv) begin
            mem_dout = rd_val;
            dv       = 1'b0;
         end
         if (mem_req != mem_req_ack) begin
            if (mcnt == 2) begin
               mem_req_ack = ~mem_req_ack;
               mcnt        = 0;
               dv          = 1'b1;
               rd_val      = 16'(mem_addr) ^ 16'hA5A5;
               mdl_tog_cyc = cyc;
            end else begin
               mcnt = mcnt + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int n, input logic we, input logic [20:1] addr,
                        input logic [15:0] din, input logic [1:0] ds);
      c_we[n]   = we;
      c_addr[n] = addr;
      c_din[n]  = din;
      c_ds[n]   = ds;
      c_req[n]  = ~c_req[n];
   endtask

   // Waits for client n to complete; returns completion cycle and prior dout
   task automatic wait_ack(input int n, output int t, output logic [15:0] pre);
      t   = -1;
      pre = c_dout[n];
      for (int k = 0; k < 60; k++) begin
         if (c_ack[n] == c_req[n]) begin
            t = cyc;
            break;
         end
         pre = c_dout[n];
         tick();
      end
      if (t < 0) chk("ack_timeout", 32'(n), 32'hFFFF_FFFF);
   endtask

   // Logs ack completions in order; client 0 re-requests on its ack up to rereq times
   task automatic collect(input int want, input int rereq);
      logic [2:0] prev;
      int left;
      left = rereq;
      log_id.delete();
      log_t.delete();
      prev = c_ack;
      for (int k = 0; k < 200; k++) begin
         if (log_id.size() >= want) break;
         tick();
         for (int n = 0; n < 3; n++) begin
            if (c_ack[n] != prev[n]) begin
               log_id.push_back(n);
               log_t.push_back(cyc);
               if (n == 0 && left > 0) begin
                  left--;
                  c_req[0] = ~c_req[0];
               end
            end
         end
         prev = c_ack;
      end
      chk("collect_cnt", 32'(log_id.size()), 32'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t2, start;
      logic [15:0] pre;
      logic addr_ok;
      int exp_ord [6];

      resetn   = 1'b0;
      mem_busy = 1'b1;
      c_req    = 3'b000;
      c_we     = 3'b000;
      for (int n = 0; n < 3; n++) begin
         c_addr[n] = '0;
         c_din[n]  = '0;
         c_ds[n]   = '0;
      end
      repeat (3) tick();
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_acks", 32'(c_ack), 32'h0);
      chk("rst_c0_dout", 32'(c_dout[0]), 32'h0);

      // Busy gating: no issue until mem_busy drops, then issue next cycle
      resetn = 1'b1;
      tick();
      issue(0, 1'b0, 20'h00ABC, 16'h0, 2'b11);
      repeat (4) tick();
      chk("busy_no_req", 32'(mem_req), 32'h0);
      mem_busy = 1'b0;
      tick();
      chk("busy_rel_req", 32'(mem_req), 32'h1);
      chk("busy_rel_addr", 32'(mem_addr), 32'h00ABC);
      wait_ack(0, t0, pre);
      chk("t1_c0_dout", 32'(c_dout[0]), 32'hAF19);

      // Double toggle before ack reads as not pending
      mem_busy = 1'b1;
      c_req[1] = ~c_req[1];
      tick();
      c_req[1] = ~c_req[1];
      tick();
      mem_busy = 1'b0;
      repeat (8) tick();
      chk("dbl_mem_req", 32'(mem_req), 32'h1);
      chk("dbl_c1_ack", 32'(c_ack[1]), 32'h0);

      // c1 write: fields latched, ack latency, dout untouched
      issue(1, 1'b1, 20'h00123, 16'hBEEF, 2'b01);
      tick();
      chk("wr_we", 32'(mem_we), 32'h1);
      chk("wr_ds", 32'(mem_ds), 32'h1);
      chk("wr_din", 32'(mem_din), 32'hBEEF);
      chk("wr_addr", 32'(mem_addr), 32'h00123);
      wait_ack(1, t0, pre);
      chk("wr_ack_lat", 32'(t0 - mdl_tog_cyc), 32'd2);
      chk("wr_c1_dout", 32'(c_dout[1]), 32'h0);

      // c0 read: dout updates together with ack, others unchanged
      issue(0, 1'b0, 20'h0B791, 16'h0, 2'b11);
      wait_ack(0, t0, pre);
      chk("rd_c0_pre", 32'(pre), 32'hAF19);
      chk("rd_c0_dout", 32'(c_dout[0]), 32'h1234);
      chk("rd_c1_dout", 32'(c_dout[1]), 32'h0);
      chk("rd_c2_dout", 32'(c_dout[2]), 32'h0);

      // All three at once, two rounds: order 0,1,2 at five-cycle spacing
      for (int r = 0; r < 2; r++) begin
         issue(0, 1'b0, 20'h00100, 16'h0, 2'b11);
         issue(1, 1'b0, 20'h00200, 16'h0, 2'b11);
         issue(2, 1'b0, 20'h00300, 16'h0, 2'b11);
         start = cyc;
         collect(3, 0);
         for (int i = 0; i < log_id.size(); i++) begin
            chk($sformatf("all3_r%0d_id%0d", r, i), 32'(log_id[i]), 32'(i));
            chk($sformatf("all3_r%0d_t%0d", r, i), 32'(log_t[i] - start), 32'(5 * (i + 1)));
         end
      end
      chk("all3_c0_dout", 32'(c_dout[0]), 32'hA4A5);
      chk("all3_c1_dout", 32'(c_dout[1]), 32'hA7A5);
      chk("all3_c2_dout", 32'(c_dout[2]), 32'hA6A5);

      // c0 re-requests on every ack, three times
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord = '{0, 1, 2, 0, 0, 0};
`else
      exp_ord = '{0, 0, 0, 0, 1, 2};
`endif
      issue(0, 1'b0, 20'h00100, 16'h0, 2'b11);
      issue(1, 1'b0, 20'h00200, 16'h0, 2'b11);
      issue(2, 1'b0, 20'h00300, 16'h0, 2'b11);
      collect(6, 3);
      for (int i = 0; i < log_id.size(); i++)
         chk($sformatf("starve_id%0d", i), 32'(log_id[i]), 32'(exp_ord[i]));

      // c2 arriving during c0 WAIT: served right after, mem_addr held
      issue(0, 1'b0, 20'h00500, 16'h0, 2'b11);
      tick();
      chk("wait_issue_addr", 32'(mem_addr), 32'h00500);
      issue(2, 1'b0, 20'h00600, 16'h0, 2'b11);
      addr_ok = 1'b1;
      t0 = -1;
      for (int k = 0; k < 60; k++) begin
         if (c_ack[0] == c_req[0]) begin
            t0 = cyc;
            break;
         end
         if (mem_addr != 20'h00500) addr_ok = 1'b0;
         tick();
      end
      chk("wait_addr_held", 32'(addr_ok), 32'h1);
      chk("wait_c0_done", 32'(t0 >= 0), 32'h1);
      wait_ack(2, t2, pre);
      chk("wait_c2_gap", 32'(t2 - t0), 32'd5);
      chk("wait_c2_dout", 32'(c_dout[2]), 32'hA3A5);

      // Reset during WAIT, then a fresh read
      issue(0, 1'b0, 20'h0B791, 16'h0, 2'b11);
      tick();
      tick();
      resetn = 1'b0;
      c_req  = 3'b000;
      tick();
      chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
      chk("mid_rst_acks", 32'(c_ack), 32'h0);
      chk("mid_rst_addr", 32'(mem_addr), 32'h0);
      chk("mid_rst_c2_dout", 32'(c_dout[2]), 32'h0);
      resetn = 1'b1;
      tick();
      issue(0, 1'b0, 20'h00ABC, 16'h0, 2'b11);
      start = cyc;
      wait_ack(0, t0, pre);
      chk("post_rst_lat", 32'(t0 - start), 32'd5);
      chk("post_rst_dout", 32'(c_dout[0]), 32'hAF19);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_rv_arbiter.md
Name: sdram_rv_arbiter

Overview:
Shares the single toggle-handshake RISC-V port of the NES SDRAM controller (bank 2, 2MB, 16-bit) between three requesters: RV instruction fetch (client 0), RV data (client 1) and the loader/OSD DMA (client 2).
- Each client sees its own toggle req/ack port with the same semantics as the controller port.
- The arbiter serialises client requests onto the controller port, one outstanding transaction at a time, and returns read data to the granted client.

Parameters:
ADDR_W, 20, word-address width; client and memory addresses are bits [ADDR_W:1].
DATA_W, 16, data width of every data port.

Ports:
clk  in  1  SDRAM clock, same clock as the SDRAM controller.
resetn  in  1  synchronous active-low reset.
mem_busy  in  1  controller init in progress; no issue while 1.
mem_addr  out  ADDR_W  latched word address to controller.
mem_din  out  DATA_W  latched write data.
mem_ds  out  2  latched byte strobes, [1]=upper byte.
mem_we  out  1  latched write flag.
mem_req  out  1  toggle request to controller.
mem_req_ack  in  1  toggle ack from controller; read data is valid on the cycle after the ack toggles.
mem_dout  in  DATA_W  read data from controller.
cN_addr  in  ADDR_W  client N address, N = 0,1,2.
cN_din  in  DATA_W  client N write data.
cN_ds  in  2  client N byte strobes.
cN_we  in  1  client N write (1) / read (0).
cN_req  in  1  client N toggle request.
cN_ack  out  1  client N toggle ack.
cN_dout  out  DATA_W  client N read data, held until that client's next read completes.

Behaviour:
- Pending condition: pend[N] = cN_req ^ cN_ack. Pending is sampled only in IDLE.
- Reset values:
  - state = IDLE; mem_req = 0; mem_addr/din/ds/we = 0.
  - all cN_ack = 0; all cN_dout = 0; grant = 0; rr_ptr = 0.
- IDLE:
  - Issues only if mem_busy = 0, mem_req == mem_req_ack, and pend != 0.
  - Selects winner g (see priority).
  - Latches cg_addr/din/ds/we into mem_* and toggles mem_req in the same cycle.
  - Stores g; goes to WAIT.
  - Client inputs may change freely after this cycle.
- WAIT: holds all mem_* stable. When mem_req_ack == mem_req, goes to DONE. There is no timeout.
- DONE (exactly one cycle; mem_dout valid this cycle):
  - If mem_we = 0, cg_dout <= mem_dout.
  - cg_ack <= ~cg_ack.
  - Updates rr_ptr; returns to IDLE.
- Timing: earliest re-issue is the cycle after DONE. Back-to-back throughput is one transaction per (controller ack latency + 2) cycles.
- Client latency: toggle req at T0 → mem_req toggles at T0+1 (if idle) → cN_ack toggles one cycle after the mem_req_ack toggle is seen. cN_dout updates in the same cycle as cN_ack.
- Priority: round-robin (see optional feature). rr_ptr = (g+1) mod 3 after each grant. Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- A client toggling req twice before its ack (protocol violation) reads as not pending. No transaction is issued for it and no ack is generated.
- Requests arriving during WAIT/DONE stay pending and are arbitrated at the next IDLE.
- Writes never modify cN_dout.
- Reset mid-transaction: returns to reset values immediately. The controller shares resetn, so toggle phases re-align at 0/0.
- Sampled-pending gating: if mem_req != mem_req_ack in IDLE (controller out of phase), the arbiter stalls; it never toggles a second time.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, client 0 > client 1 > client 2. rr_ptr is absent; a continuously requesting client 0 can starve others.

Test Plan:
1. Reset then mem_busy = 1 with c0 toggling req: no mem_req toggle until mem_busy = 0; then mem_req toggles on the next cycle with mem_addr = c0_addr.
2. c1 write addr 0x00123, din 0xBEEF, ds 2'b01: mem_we = 1, mem_ds = 01, mem_din = 0xBEEF. c1_ack toggles one cycle after the model's ack toggle; c1_dout stays 0.
3. c0 read, model returns 0x1234 the cycle after its ack: c0_dout = 0x1234 in the same cycle c0_ack toggles. c1_dout and c2_dout are unchanged.
4. All three toggle req in the same cycle with round-robin enabled: grant order 0, 1, 2. Re-request all three: order is again 0, 1, 2. With the macro undefined and c0 re-requesting immediately after every ack: c0 is served continuously and c1/c2 only once c0 stops.
5. c2 toggles req while c0 is in WAIT: c2 is served immediately after c0's DONE. mem_addr stays at c0_addr throughout WAIT.
6. Assert resetn = 0 during WAIT: the next cycle shows state IDLE, mem_req = 0 and all acks = 0. After release, a fresh c0 read completes normally.
